// File: rtl/vend_multi.sv
// vend_multi: multi-product vending controller.
// Accumulates coin credit (0.5 yuan units), vends a selected item when credit
// covers its price, pays change, refunds on give_up or inactivity timeout.
// Optional feature macro: AUTO_VEND_EN -- when defined, an accepted coin that
// brings credit up to the price of the held selection vends on the next edge.
module vend_multi #(
  parameter int N_ITEM = 4,
  parameter int SEL_W = 2,
  parameter int CREDIT_W = 6,
  parameter logic [N_ITEM*CREDIT_W-1:0] PRICE_LIST = {6'd3, 6'd6, 6'd4, 6'd5},
  parameter int MAX_CREDIT = 40,
  parameter int TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          in_m,
  input  logic [SEL_W-1:0]    sel,
  input  logic                buy,
  input  logic                give_up,
  output logic                out_item_vld,
  output logic [SEL_W-1:0]    out_item,
  output logic                out_m_vld,
  output logic [CREDIT_W-1:0] out_m,
  output logic                out_reject,
  output logic                out_short,
  output logic [CREDIT_W-1:0] credit
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W + 1)'(MAX_CREDIT);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISP} state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [CREDIT_W-1:0] credit_n;
  logic                item_vld_n, m_vld_n, reject_n, short_n;
  logic [SEL_W-1:0]    item_n;
  logic [CREDIT_W-1:0] m_n;
  logic [CREDIT_W-1:0] sel_price, coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                taken, timed_out;

`ifdef AUTO_VEND_EN
  logic                auto_pend, auto_pend_n;
  logic [SEL_W-1:0]    auto_item, auto_item_n;
  logic [CREDIT_W-1:0] auto_price;
`endif

  // Price lookup; out-of-range selects return 0, which also marks a disabled item
  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] s);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int i = 0; i < N_ITEM; i++) begin
      if (s == SEL_W'(i)) p = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
    end
    return p;
  endfunction

  // Coin code to credit units
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] m);
    case (m)
      2'd1:    return CREDIT_W'(1);
      2'd2:    return CREDIT_W'(2);
      2'd3:    return CREDIT_W'(10);
      default: return '0;
    endcase
  endfunction

  // Next-state and next-output logic: give_up/timeout, then buy, then coin
  always_comb begin
    state_n    = state;
    credit_n   = credit;
    cnt_n      = '0;
    item_vld_n = 1'b0;
    item_n     = '0;
    m_vld_n    = 1'b0;
    m_n        = '0;
    reject_n   = 1'b0;
    short_n    = 1'b0;
    taken      = 1'b0;
    sel_price  = price_of(sel);
    coin_val   = coin_value(in_m);
    coin_sum   = {1'b0, credit} + {1'b0, coin_val};
    timed_out  = (TIMEOUT != 0) && (state == S_CREDIT) && (cnt == TO_LIM);
`ifdef AUTO_VEND_EN
    auto_pend_n = 1'b0;
    auto_item_n = auto_item;
    auto_price  = price_of(auto_item);
`endif
    if (state == S_DISP) begin
      // Dispense cycle: every request is ignored, any coin bounces
      state_n  = S_IDLE;
      reject_n = (in_m != 2'd0);
    end else begin
      if ((give_up || timed_out) && credit != '0) begin
        m_vld_n  = 1'b1;
        m_n      = credit;
        credit_n = '0;
        state_n  = S_DISP;
        taken    = 1'b1;
      end else if (buy) begin
        if (sel_price == '0 || credit < sel_price) begin
          short_n = 1'b1;
        end else begin
          item_vld_n = 1'b1;
          item_n     = sel;
          m_vld_n    = (credit != sel_price);
          m_n        = credit - sel_price;
          credit_n   = '0;
          state_n    = S_DISP;
          taken      = 1'b1;
        end
      end
`ifdef AUTO_VEND_EN
      else if (auto_pend) begin
        // Credit cannot drop between the arming coin and this edge
        item_vld_n = 1'b1;
        item_n     = auto_item;
        m_vld_n    = (credit != auto_price);
        m_n        = credit - auto_price;
        credit_n   = '0;
        state_n    = S_DISP;
        taken      = 1'b1;
      end
`endif
      if (in_m != 2'd0) begin
        if (taken || coin_sum > MAX_C) begin
          reject_n = 1'b1;
        end else begin
          credit_n = coin_sum[CREDIT_W-1:0];
          state_n  = S_CREDIT;
`ifdef AUTO_VEND_EN
          if (sel_price != '0 && coin_sum[CREDIT_W-1:0] >= sel_price) begin
            auto_pend_n = 1'b1;
            auto_item_n = sel;
          end
`endif
        end
      end
      // Idle counter only runs while holding credit with no activity at all
      if (TIMEOUT != 0 && state == S_CREDIT && !taken &&
          in_m == 2'd0 && !buy && !give_up) begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Credit, idle counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit       <= '0;
      cnt          <= '0;
      out_item_vld <= 1'b0;
      out_item     <= '0;
      out_m_vld    <= 1'b0;
      out_m        <= '0;
      out_reject   <= 1'b0;
      out_short    <= 1'b0;
    end else begin
      credit       <= credit_n;
      cnt          <= cnt_n;
      out_item_vld <= item_vld_n;
      out_item     <= item_n;
      out_m_vld    <= m_vld_n;
      out_m        <= m_n;
      out_reject   <= reject_n;
      out_short    <= short_n;
    end
  end

`ifdef AUTO_VEND_EN
  // Pending automatic vend armed by the coin that reached the price
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_pend <= 1'b0;
      auto_item <= '0;
    end else begin
      auto_pend <= auto_pend_n;
      auto_item <= auto_item_n;
    end
  end
`endif

endmodule
